// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bundle: redirect/flush controls, Wishbone instruction-bus master and decode-side queue head.
interface fetch_queue_stage_if;
    logic        if_stall_i;
    logic        if_flush_i;
    logic [1:0]  if_pc_sel_i;
    logic [31:0] pc_branch_address_i;
    logic [31:0] pc_jump_address_i;

    logic [31:0] iwbm_addr_o;
    logic        iwbm_cyc_o;
    logic        iwbm_stb_o;
    logic [31:0] iwbm_dat_i;
    logic        iwbm_ack_i;
    logic        iwbm_err_i;

    logic        id_valid_o;
    logic [31:0] id_instruction_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_add4_o;
    logic        id_exc_addr_o;
    logic        id_exc_fault_o;

    modport master (
        input  if_stall_i, if_flush_i, if_pc_sel_i, pc_branch_address_i, pc_jump_address_i,
        input  iwbm_dat_i, iwbm_ack_i, iwbm_err_i,
        output iwbm_addr_o, iwbm_cyc_o, iwbm_stb_o,
        output id_valid_o, id_instruction_o, id_pc_o, id_pc_add4_o, id_exc_addr_o, id_exc_fault_o
    );

    modport slave (
        output if_stall_i, if_flush_i, if_pc_sel_i, pc_branch_address_i, pc_jump_address_i,
        output iwbm_dat_i, iwbm_ack_i, iwbm_err_i,
        input  iwbm_addr_o, iwbm_cyc_o, iwbm_stb_o,
        input  id_valid_o, id_instruction_o, id_pc_o, id_pc_add4_o, id_exc_addr_o, id_exc_fault_o
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Wishbone fetch into a DEPTH-entry show-ahead queue; ack in M shows at head in M+1, stall holds the head and fills the queue.
// FETCH_BUS_ERR_EN: bus errors become halting fault entries; otherwise err is treated as ack.
module fetch_queue_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    fetch_queue_stage_if.master bus
);
    localparam int              PW   = $clog2(DEPTH);
    localparam int              CW   = PW + 1;
    localparam logic [31:0]     NOP  = 32'h0000_0013;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_add4;
        logic [31:0] inst;
        logic        exc_addr;
        logic        exc_fault;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          halt_q, halt_d;
    entry_t        mem_q [DEPTH];

    logic          push, pop, redirect, clear, bus_done, bus_busy;
    logic [31:0]   target, new_pc;
    logic [PW-1:0] push_idx;
    entry_t        push_entry, head;

    assign redirect = (bus.if_pc_sel_i == 2'b01) || (bus.if_pc_sel_i == 2'b10);
    assign target   = (bus.if_pc_sel_i == 2'b10) ? bus.pc_jump_address_i : bus.pc_branch_address_i;
    assign clear    = redirect || bus.if_flush_i;
    assign new_pc   = redirect ? target : fpc_q;
    assign bus_done = bus.iwbm_ack_i || bus.iwbm_err_i;
    assign bus_busy = (state_q != IDLE) && !bus_done;
    assign pop      = (count_q != '0) && !bus.if_stall_i;
    assign head     = mem_q[rd_q];

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        halt_d     = halt_q;
        push       = 1'b0;
        push_idx   = wr_q;
        push_entry = '0;

        if (clear) begin
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            fpc_d   = new_pc;
            if (redirect) halt_d = 1'b0;
            if (redirect && (target[1:0] != 2'b00)) begin
                push       = 1'b1;
                push_idx   = '0;
                push_entry = '{pc: target, pc_add4: target + 32'd4, inst: NOP,
                               exc_addr: 1'b1, exc_fault: 1'b0};
                count_d    = CW'(1);
                wr_d       = PW'(1);
                halt_d     = 1'b1;
            end
            // A live bus cycle must still be terminated; otherwise refetch starts straight away.
            if (bus_busy) begin
                state_d = DISCARD;
            end else if (!halt_d) begin
                state_d = REQ;
                addr_d  = new_pc;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (((count_q != FULL) || pop) && !halt_q) begin
                        state_d = REQ;
                        addr_d  = fpc_q;
                    end
                end
                REQ: begin
                    if (bus_done) begin
                        state_d = IDLE;
                        push    = 1'b1;
`ifdef FETCH_BUS_ERR_EN
                        if (bus.iwbm_err_i) begin
                            push_entry = '{pc: fpc_q, pc_add4: fpc_q + 32'd4, inst: NOP,
                                           exc_addr: 1'b0, exc_fault: 1'b1};
                            halt_d     = 1'b1;
                        end else begin
                            push_entry = '{pc: fpc_q, pc_add4: fpc_q + 32'd4, inst: bus.iwbm_dat_i,
                                           exc_addr: 1'b0, exc_fault: 1'b0};
                            fpc_d      = fpc_q + 32'd4;
                        end
`else
                        push_entry = '{pc: fpc_q, pc_add4: fpc_q + 32'd4, inst: bus.iwbm_dat_i,
                                       exc_addr: 1'b0, exc_fault: 1'b0};
                        fpc_d      = fpc_q + 32'd4;
`endif
                    end
                end
                DISCARD: begin
                    if (bus_done) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (pop)  rd_d = rd_q + PW'(1);
            if (push) wr_d = wr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            fpc_q   <= RESET_ADDR;
            addr_q  <= '0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            halt_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            halt_q  <= halt_d;
            if (push) mem_q[push_idx] <= push_entry;
        end
    end

    assign bus.iwbm_addr_o      = addr_q;
    assign bus.iwbm_cyc_o       = (state_q != IDLE);
    assign bus.iwbm_stb_o       = (state_q != IDLE);
    assign bus.id_valid_o       = (count_q != '0);
    assign bus.id_instruction_o = head.inst;
    assign bus.id_pc_o          = head.pc;
    assign bus.id_pc_add4_o     = head.pc_add4;
    assign bus.id_exc_addr_o    = head.exc_addr;
    // Fault entries are only ever created with FETCH_BUS_ERR_EN, so this reads 0 otherwise.
    assign bus.id_exc_fault_o   = head.exc_fault;
endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised instruction-fetch stage with a Wishbone instruction-bus master, a DEPTH-entry prefetch queue and branch/jump redirect with in-flight cancellation. Sits between the PC redirect logic in EX/ID and the decode stage; replaces the single-register IF/ID hand-off with a valid/stall-qualified queue head. Misaligned targets and, optionally, bus errors travel down the pipe as tagged entries.

## Interface
- RESET_ADDR, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4: queue entries; power of two, 2..16.
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- if_stall_i  in  1  decode not accepting; head held.
- if_flush_i  in  1  empty queue, cancel in-flight fetch, PC unchanged.
- if_pc_sel_i  in  2  00 sequential, 01 branch, 10 jump, 11 treated as 00.
- pc_branch_address_i  in  32  target for sel=01.
- pc_jump_address_i  in  32  target for sel=10.
- iwbm_addr_o  out  32  fetch address.
- iwbm_cyc_o / iwbm_stb_o  out  1  bus cycle/strobe, asserted together.
- iwbm_dat_i  in  32  instruction word.
- iwbm_ack_i  in  1  transfer done.
- iwbm_err_i  in  1  bus error (see Configuration).
- id_valid_o  out  1  queue head valid.
- id_instruction_o / id_pc_o / id_pc_add4_o  out  32  head fields.
- id_exc_addr_o  out  1  head is misaligned-fetch exception.
- id_exc_fault_o  out  1  head is bus-fault exception.

## Operation
- State: fetch PC fpc (32), count (clog2(DEPTH)+1), wr/rd pointers, FSM {IDLE, REQ, DISCARD}, halt flag.
- Entry = {pc, pc+4, inst, exc_addr, exc_fault}; outputs are the registered head entry (show-ahead).
- IDLE: if count < DEPTH, !halt, no redirect/flush: go REQ, addr=fpc, cyc=stb=1.
- REQ: hold addr/cyc/stb until ack or err. On ack: push {fpc, fpc+4, dat, 0, 0}, fpc += 4 (mod 2^32), go IDLE. Slot guaranteed: count only falls while in REQ.
- Redirect = if_pc_sel_i in {01,10}: queue emptied, fpc <= target, halt cleared; in REQ without ack/err this cycle -> DISCARD; otherwise IDLE.
- Misaligned target (target[1:0] != 0): no bus cycle; push one entry {target, target+4, 32'h0000_0013, exc_addr=1, 0}, set halt; halt cleared only by redirect or reset.
- if_flush_i: as redirect but fpc kept; redirect wins if both asserted.
- DISCARD: keep cyc/stb/addr until ack or err, drop data, go IDLE.
- Pop when id_valid_o && !if_stall_i. Push+pop same cycle: count unchanged. Redirect/flush overrides pop and push.

## Timing
- Reset: all id_* and iwbm_* outputs 0, id_valid_o 0, fpc=RESET_ADDR, FSM IDLE, count 0, halt 0.
- First request asserted cycle 1 after reset release.
- Same-cycle ack permitted; ack in cycle M -> entry on outputs, id_valid_o=1 at M+1.
- cyc/stb deassert one cycle after each ack: peak one word per 2 cycles.
- Redirect in cycle N (bus idle or ack in N): request to target in N+1; id_valid_o 0 in N+1.
- Redirect during pending cycle: no new request until the cycle after the discarded ack.
- Queue full: IDLE holds with cyc=0 until a pop frees a slot; request issues the cycle after.

## Configuration
- FETCH_BUS_ERR_EN defined: err in REQ pushes {fpc, fpc+4, 32'h0000_0013, 0, exc_fault=1}, sets halt, fpc unchanged; err in DISCARD dropped.
- Undefined: iwbm_err_i treated as ack (data pushed as-is), id_exc_fault_o tied 0.

## Test plan
- Reset with RESET_ADDR=32'h100, ack 2 cycles after stb -> addresses 0x100, 0x104, 0x108 in order; id_pc_add4_o = id_pc_o+4.
- if_stall_i=1 for 20 cycles, DEPTH=4 -> exactly 4 bus cycles, then cyc=0; release -> 4 heads popped in order, fetch resumes at 0x110.
- Jump to 0x2000 while REQ pending for 0x108 -> 0x108 data never appears; next request 0x2000 after its ack; queue empty meanwhile.
- Branch to 0x3002 -> no bus cycle; one entry pc=0x3002, inst=0x13, id_exc_addr_o=1; fetch halted until jump to 0x4000.
- Branch and ack in same cycle -> acked word dropped, next request to target the following cycle.
- With FETCH_BUS_ERR_EN, err on 0x500 -> entry pc=0x500, id_exc_fault_o=1, halt; without macro -> word pushed, fault 0, fetch continues at 0x504.
